// File: rtl/si_fetch_unit.sv
// ----------------------------------------------------------------------------
// si_fetch_unit
//
// Single-outstanding instruction fetch stage. Issues one request to
// instruction memory, waits for the response, then holds the fetched word
// for decode until it is consumed. A redirect from branch/jump logic wins
// over every other event: it reloads the PC (forced to word alignment) and
// discards whatever is in flight or being held.
//
// Ports
//   clk               clock, rising edge
//   rst               asynchronous reset, active low
//   control_en_i      redirect request
//   control_pc_i      redirect target (low two bits flag misalignment)
//   imem_req_valid_o  fetch request valid
//   imem_req_addr_o   fetch address (current PC)
//   imem_req_ready_i  memory accepts request
//   imem_rsp_valid_i  response valid
//   imem_rsp_data_i   response instruction word
//   inst_valid_o      instruction available to decode
//   inst_o            held instruction
//   inst_pc_o         PC of the held instruction
//   inst_ready_i      decode consumes the instruction
//   misalign_o        one-cycle pulse after a misaligned redirect
//   inst_cnt_o        number of instructions consumed by decode
// ----------------------------------------------------------------------------
module si_fetch_unit #(
    parameter int unsigned          INST_DW  = 32,
    parameter int unsigned          INST_AW  = 32,
    parameter logic [INST_AW-1:0]   PC_START = 32'h8000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 control_en_i,
    input  logic [INST_AW-1:0]   control_pc_i,
    output logic                 imem_req_valid_o,
    output logic [INST_AW-1:0]   imem_req_addr_o,
    input  logic                 imem_req_ready_i,
    input  logic                 imem_rsp_valid_i,
    input  logic [INST_DW-1:0]   imem_rsp_data_i,
    output logic                 inst_valid_o,
    output logic [INST_DW-1:0]   inst_o,
    output logic [INST_AW-1:0]   inst_pc_o,
    input  logic                 inst_ready_i,
    output logic                 misalign_o,
    output logic [31:0]          inst_cnt_o
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t               r_state, w_state_d;
    logic [INST_AW-1:0]   r_pc, w_pc_d;
    logic                 r_drop, w_drop_d;
    logic [INST_DW-1:0]   r_inst, w_inst_d;
    logic [INST_AW-1:0]   r_inst_pc, w_inst_pc_d;
    logic                 r_misalign, w_misalign_d;
    logic [31:0]          r_cnt, w_cnt_d;

    logic [INST_AW-1:0]   w_redirect_pc;

    assign w_redirect_pc = {control_pc_i[INST_AW-1:2], 2'b00};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_REQ;
            r_pc       <= PC_START;
            r_drop     <= 1'b0;
            r_inst     <= '0;
            r_inst_pc  <= '0;
            r_misalign <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_d;
            r_pc       <= w_pc_d;
            r_drop     <= w_drop_d;
            r_inst     <= w_inst_d;
            r_inst_pc  <= w_inst_pc_d;
            r_misalign <= w_misalign_d;
            r_cnt      <= w_cnt_d;
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_pc_d       = r_pc;
        w_drop_d     = r_drop;
        w_inst_d     = r_inst;
        w_inst_pc_d  = r_inst_pc;
        w_cnt_d      = r_cnt;
        w_misalign_d = control_en_i & (control_pc_i[1:0] != 2'b00);

        if (control_en_i) begin
            w_pc_d = w_redirect_pc;
            unique case (r_state)
                S_WAIT: begin
                    if (imem_rsp_valid_i) begin
                        // The in-flight response lands this cycle and is thrown
                        // away here, so nothing remains to be dropped later.
                        w_state_d = S_REQ;
                        w_drop_d  = 1'b0;
                    end else begin
                        // Response still outstanding: stay until it arrives
                        // and discard it then.
                        w_drop_d  = 1'b1;
                    end
                end
                default: w_state_d = S_REQ;
            endcase
        end else begin
            unique case (r_state)
                S_REQ: begin
                    if (imem_req_ready_i) begin
                        w_state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid_i) begin
                        if (r_drop) begin
                            w_drop_d  = 1'b0;
                            w_state_d = S_REQ;
                        end else begin
                            w_inst_d    = imem_rsp_data_i;
                            w_inst_pc_d = r_pc;
                            w_pc_d      = r_pc + INST_AW'(4);
                            w_state_d   = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (inst_ready_i) begin
                        w_cnt_d   = r_cnt + 32'd1;
                        w_state_d = S_REQ;
                    end
                end
                default: w_state_d = S_REQ;
            endcase
        end
    end

    // A redirect in S_REQ suppresses the request for that cycle.
    assign imem_req_valid_o = (r_state == S_REQ) & ~control_en_i;
    assign imem_req_addr_o  = r_pc;
    assign inst_valid_o     = (r_state == S_HOLD);
    assign inst_o           = r_inst;
    assign inst_pc_o        = r_inst_pc;
    assign misalign_o       = r_misalign;
    assign inst_cnt_o       = r_cnt;

endmodule

// File: tb/tb_si_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_si_fetch_unit
//
// Directed scenarios for reset, basic fetch, redirects and stalls, followed
// by a randomized run against a transaction-level reference model.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// ----------------------------------------------------------------------------
module tb_si_fetch_unit;

    logic        clk;
    logic        rst;
    logic        control_en_i;
    logic [31:0] control_pc_i;
    logic        imem_req_valid_o;
    logic [31:0] imem_req_addr_o;
    logic        imem_req_ready_i;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_ready_i;
    logic        misalign_o;
    logic [31:0] inst_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    si_fetch_unit #(
        .INST_DW  (32),
        .INST_AW  (32),
        .PC_START (32'h8000_0000)
    ) u_dut (
        .clk              (clk),
        .rst              (rst),
        .control_en_i     (control_en_i),
        .control_pc_i     (control_pc_i),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .inst_valid_o     (inst_valid_o),
        .inst_o           (inst_o),
        .inst_pc_o        (inst_pc_o),
        .inst_ready_i     (inst_ready_i),
        .misalign_o       (misalign_o),
        .inst_cnt_o       (inst_cnt_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic idle_inputs();
        control_en_i     = 1'b0;
        control_pc_i     = 32'h0;
        imem_req_ready_i = 1'b0;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = 32'h0;
        inst_ready_i     = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        #1;
        n_checks++; if (inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_inst_valid: got %b want 0", inst_valid_o); end
        n_checks++; if (inst_o !== 32'h0) begin n_fail++; $display("FAIL reset_inst: got %h want 0", inst_o); end
        n_checks++; if (inst_pc_o !== 32'h0) begin n_fail++; $display("FAIL reset_inst_pc: got %h want 0", inst_pc_o); end
        n_checks++; if (misalign_o !== 1'b0) begin n_fail++; $display("FAIL reset_misalign: got %b want 0", misalign_o); end
        n_checks++; if (inst_cnt_o !== 32'h0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", inst_cnt_o); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++; if (imem_req_valid_o !== 1'b1) begin n_fail++; $display("FAIL release_req_valid: got %b want 1", imem_req_valid_o); end
        n_checks++; if (imem_req_addr_o !== 32'h8000_0000) begin n_fail++; $display("FAIL release_addr: got %h want 80000000", imem_req_addr_o); end
    endtask

    // Request accepted, response two cycles later, consumed immediately.
    task automatic test_basic_fetch();
        @(negedge clk); idle_inputs(); imem_req_ready_i = 1'b1;
        @(negedge clk); idle_inputs(); #1;
        n_checks++; if (imem_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_wait_req_valid: got %b want 0", imem_req_valid_o); end
        @(negedge clk); imem_rsp_valid_i = 1'b1; imem_rsp_data_i = 32'h0000_0013;
        @(negedge clk); idle_inputs(); inst_ready_i = 1'b1; #1;
        n_checks++; if (inst_valid_o !== 1'b1) begin n_fail++; $display("FAIL basic_inst_valid: got %b want 1", inst_valid_o); end
        n_checks++; if (inst_o !== 32'h0000_0013) begin n_fail++; $display("FAIL basic_inst: got %h want 00000013", inst_o); end
        n_checks++; if (inst_pc_o !== 32'h8000_0000) begin n_fail++; $display("FAIL basic_inst_pc: got %h want 80000000", inst_pc_o); end
        @(negedge clk); idle_inputs(); #1;
        n_checks++; if (inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_consumed_valid: got %b want 0", inst_valid_o); end
        n_checks++; if (inst_cnt_o !== 32'd1) begin n_fail++; $display("FAIL basic_cnt: got %0d want 1", inst_cnt_o); end
        n_checks++; if (imem_req_valid_o !== 1'b1) begin n_fail++; $display("FAIL basic_next_req_valid: got %b want 1", imem_req_valid_o); end
        n_checks++; if (imem_req_addr_o !== 32'h8000_0004) begin n_fail++; $display("FAIL basic_next_addr: got %h want 80000004", imem_req_addr_o); end
    endtask

    // Redirect while waiting; the late response must be dropped.
    task automatic test_redirect_wait();
        @(negedge clk); idle_inputs(); imem_req_ready_i = 1'b1;
        @(negedge clk); idle_inputs(); control_en_i = 1'b1; control_pc_i = 32'h8000_0100;
        @(negedge clk); idle_inputs(); imem_rsp_valid_i = 1'b1; imem_rsp_data_i = 32'hDEAD_BEEF; #1;
        n_checks++; if (inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL rdw_valid_before: got %b want 0", inst_valid_o); end
        @(negedge clk); idle_inputs(); #1;
        n_checks++; if (inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL rdw_valid_after: got %b want 0", inst_valid_o); end
        n_checks++; if (imem_req_valid_o !== 1'b1) begin n_fail++; $display("FAIL rdw_req_valid: got %b want 1", imem_req_valid_o); end
        n_checks++; if (imem_req_addr_o !== 32'h8000_0100) begin n_fail++; $display("FAIL rdw_addr: got %h want 80000100", imem_req_addr_o); end
        n_checks++; if (inst_cnt_o !== 32'd1) begin n_fail++; $display("FAIL rdw_cnt: got %0d want 1", inst_cnt_o); end
    endtask

    // Decode stalls five cycles; everything must hold still.
    task automatic test_hold_stall();
        logic [31:0] data;
        data = $urandom;
        @(negedge clk); idle_inputs(); imem_req_ready_i = 1'b1;
        @(negedge clk); idle_inputs(); imem_rsp_valid_i = 1'b1; imem_rsp_data_i = data;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); idle_inputs(); #1;
            n_checks++; if (inst_valid_o !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b want 1", i, inst_valid_o); end
            n_checks++; if (inst_o !== data) begin n_fail++; $display("FAIL stall_inst[%0d]: got %h want %h", i, inst_o, data); end
            n_checks++; if (inst_pc_o !== 32'h8000_0100) begin n_fail++; $display("FAIL stall_pc[%0d]: got %h want 80000100", i, inst_pc_o); end
            n_checks++; if (imem_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL stall_req[%0d]: got %b want 0", i, imem_req_valid_o); end
            n_checks++; if (inst_cnt_o !== 32'd1) begin n_fail++; $display("FAIL stall_cnt[%0d]: got %0d want 1", i, inst_cnt_o); end
        end
        @(negedge clk); idle_inputs(); inst_ready_i = 1'b1;
        @(negedge clk); idle_inputs(); #1;
        n_checks++; if (inst_cnt_o !== 32'd2) begin n_fail++; $display("FAIL stall_cnt_after: got %0d want 2", inst_cnt_o); end
        n_checks++; if (imem_req_addr_o !== 32'h8000_0104) begin n_fail++; $display("FAIL stall_next_addr: got %h want 80000104", imem_req_addr_o); end
    endtask

    task automatic test_misalign();
        @(negedge clk); idle_inputs(); control_en_i = 1'b1; control_pc_i = 32'h8000_0202; #1;
        n_checks++; if (imem_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL mis_req_suppressed: got %b want 0", imem_req_valid_o); end
        @(negedge clk); idle_inputs(); #1;
        n_checks++; if (misalign_o !== 1'b1) begin n_fail++; $display("FAIL mis_pulse: got %b want 1", misalign_o); end
        n_checks++; if (imem_req_addr_o !== 32'h8000_0200) begin n_fail++; $display("FAIL mis_addr: got %h want 80000200", imem_req_addr_o); end
        @(negedge clk); idle_inputs(); #1;
        n_checks++; if (misalign_o !== 1'b0) begin n_fail++; $display("FAIL mis_pulse_end: got %b want 0", misalign_o); end
    endtask

    // Redirect and consume in the same cycle: the redirect wins.
    task automatic test_redirect_hold();
        @(negedge clk); idle_inputs(); imem_req_ready_i = 1'b1;
        @(negedge clk); idle_inputs(); imem_rsp_valid_i = 1'b1; imem_rsp_data_i = 32'h1234_5678;
        @(negedge clk); idle_inputs(); control_en_i = 1'b1; control_pc_i = 32'h8000_0300; inst_ready_i = 1'b1; #1;
        n_checks++; if (inst_pc_o !== 32'h8000_0200) begin n_fail++; $display("FAIL rdh_inst_pc: got %h want 80000200", inst_pc_o); end
        @(negedge clk); idle_inputs(); #1;
        n_checks++; if (inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL rdh_valid: got %b want 0", inst_valid_o); end
        n_checks++; if (inst_cnt_o !== 32'd2) begin n_fail++; $display("FAIL rdh_cnt: got %0d want 2", inst_cnt_o); end
        n_checks++; if (imem_req_addr_o !== 32'h8000_0300) begin n_fail++; $display("FAIL rdh_addr: got %h want 80000300", imem_req_addr_o); end
        n_checks++; if (misalign_o !== 1'b0) begin n_fail++; $display("FAIL rdh_misalign: got %b want 0", misalign_o); end
    endtask

    // Reset asserted mid-wait, then a stray response after release.
    task automatic test_async_reset();
        @(negedge clk); idle_inputs(); imem_req_ready_i = 1'b1;
        @(negedge clk); idle_inputs();
        #3 rst = 1'b0;
        #1;
        n_checks++; if (inst_cnt_o !== 32'd0) begin n_fail++; $display("FAIL arst_cnt: got %0d want 0", inst_cnt_o); end
        n_checks++; if (inst_o !== 32'h0) begin n_fail++; $display("FAIL arst_inst: got %h want 0", inst_o); end
        n_checks++; if (inst_pc_o !== 32'h0) begin n_fail++; $display("FAIL arst_inst_pc: got %h want 0", inst_pc_o); end
        n_checks++; if (imem_req_addr_o !== 32'h8000_0000) begin n_fail++; $display("FAIL arst_addr: got %h want 80000000", imem_req_addr_o); end
        n_checks++; if (imem_req_valid_o !== 1'b1) begin n_fail++; $display("FAIL arst_req_valid: got %b want 1", imem_req_valid_o); end
        @(negedge clk); rst = 1'b1; imem_rsp_valid_i = 1'b1; imem_rsp_data_i = 32'hCAFE_F00D;
        @(negedge clk); idle_inputs(); #1;
        n_checks++; if (inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL arst_stray_valid: got %b want 0", inst_valid_o); end
        n_checks++; if (imem_req_valid_o !== 1'b1) begin n_fail++; $display("FAIL arst_post_req: got %b want 1", imem_req_valid_o); end
        n_checks++; if (imem_req_addr_o !== 32'h8000_0000) begin n_fail++; $display("FAIL arst_post_addr: got %h want 80000000", imem_req_addr_o); end
    endtask

    // Randomized run. The model tracks facts about transactions: whether a
    // request is in flight, whether its reply is owed to nobody, and whether
    // an instruction is sitting with decode.
    task automatic test_random();
        logic [31:0] m_pc      = 32'h8000_0000;
        logic        m_out     = 1'b0;
        logic        m_discard = 1'b0;
        logic        m_have    = 1'b0;
        logic [31:0] m_inst    = 32'h0;
        logic [31:0] m_inst_pc = 32'h0;
        logic [31:0] m_cnt     = 32'h0;
        logic        m_mis     = 1'b0;
        int          mem_wait  = 0;
        logic        exp_req;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            idle_inputs();
            control_en_i     = ($urandom_range(0, 7) == 0);
            control_pc_i     = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(0, 3)))
                                                          : $urandom;
            imem_req_ready_i = $urandom_range(0, 1) == 1;
            inst_ready_i     = $urandom_range(0, 1) == 1;
            imem_rsp_data_i  = $urandom;
            if (m_out) imem_rsp_valid_i = (mem_wait == 0);
            else       imem_rsp_valid_i = ($urandom_range(0, 7) == 0);
            #1;
            exp_req = !m_out && !m_have && !control_en_i;
            n_checks++; if (imem_req_valid_o !== exp_req) begin n_fail++; $display("FAIL rnd_req_valid @%0d: got %b want %b", cyc, imem_req_valid_o, exp_req); end
            n_checks++; if (imem_req_addr_o !== m_pc) begin n_fail++; $display("FAIL rnd_addr @%0d: got %h want %h", cyc, imem_req_addr_o, m_pc); end
            n_checks++; if (inst_valid_o !== m_have) begin n_fail++; $display("FAIL rnd_inst_valid @%0d: got %b want %b", cyc, inst_valid_o, m_have); end
            n_checks++; if (inst_o !== m_inst) begin n_fail++; $display("FAIL rnd_inst @%0d: got %h want %h", cyc, inst_o, m_inst); end
            n_checks++; if (inst_pc_o !== m_inst_pc) begin n_fail++; $display("FAIL rnd_inst_pc @%0d: got %h want %h", cyc, inst_pc_o, m_inst_pc); end
            n_checks++; if (misalign_o !== m_mis) begin n_fail++; $display("FAIL rnd_misalign @%0d: got %b want %b", cyc, misalign_o, m_mis); end
            n_checks++; if (inst_cnt_o !== m_cnt) begin n_fail++; $display("FAIL rnd_cnt @%0d: got %0d want %0d", cyc, inst_cnt_o, m_cnt); end

            // Advance the model by what happens at the coming rising edge.
            m_mis = control_en_i && (control_pc_i % 4 != 0);
            if (m_out && mem_wait > 0) mem_wait--;
            if (control_en_i) begin
                m_pc = control_pc_i - (control_pc_i % 4);
                if (m_have) m_have = 1'b0;
                else if (m_out) begin
                    if (imem_rsp_valid_i) begin m_out = 1'b0; m_discard = 1'b0; end
                    else m_discard = 1'b1;
                end
            end else if (m_have) begin
                if (inst_ready_i) begin m_have = 1'b0; m_cnt = m_cnt + 1; end
            end else if (m_out) begin
                if (imem_rsp_valid_i) begin
                    m_out = 1'b0;
                    if (m_discard) m_discard = 1'b0;
                    else begin
                        m_have = 1'b1; m_inst = imem_rsp_data_i; m_inst_pc = m_pc;
                        m_pc = m_pc + 4;
                    end
                end
            end else if (imem_req_ready_i) begin
                m_out    = 1'b1;
                mem_wait = $urandom_range(0, 3);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_redirect_wait();
        test_hold_stall();
        test_misalign();
        test_redirect_hold();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/si_fetch_unit.md
SI_FETCH_UNIT -- requirements
Module: si_fetch_unit

Interface
REQ-001 Parameter PC_START, default 32'h8000_0000, is the first fetch address after reset.
REQ-002 Parameter INST_DW, default 32, is the instruction width.
REQ-003 Parameter INST_AW, default 32, is the address/PC width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous assertion, active-low (0 = reset).
REQ-006 control_en_i  input  1  redirect request from ALU branch/jump logic.
REQ-007 control_pc_i  input  INST_AW  redirect target PC.
REQ-008 imem_req_valid_o  output  1  fetch request valid.
REQ-009 imem_req_addr_o  output  INST_AW  fetch address.
REQ-010 imem_req_ready_i  input  1  memory accepts request.
REQ-011 imem_rsp_valid_i  input  1  fetch data valid.
REQ-012 imem_rsp_data_i  input  INST_DW  fetched instruction word.
REQ-013 inst_valid_o  output  1  instruction available to decode.
REQ-014 inst_o  output  INST_DW  held instruction.
REQ-015 inst_pc_o  output  INST_AW  PC of inst_o.
REQ-016 inst_ready_i  input  1  decode consumes instruction.
REQ-017 misalign_o  output  1  one-cycle pulse: redirect target with bits[1:0] != 0.
REQ-018 inst_cnt_o  output  32  count of delivered instructions.

Function
REQ-019 FSM states SHALL be S_REQ, S_WAIT, S_HOLD; one outstanding request max.
REQ-020 S_REQ: imem_req_valid_o = ~control_en_i (combinational); imem_req_addr_o = pc; valid & ready -> S_WAIT.
REQ-021 S_WAIT: on imem_rsp_valid_i with drop=0, capture inst_o <= data, inst_pc_o <= pc, pc <= pc+4 (wraps mod 2^INST_AW), -> S_HOLD.
REQ-022 S_HOLD: inst_valid_o = 1; on inst_ready_i -> S_REQ, inst_valid_o low next cycle, inst_cnt_o += 1 (wraps at 2^32).
REQ-023 Latency: request accepted cycle N, response cycle M>N -> inst_valid_o high cycle M+1; next request issued one cycle after consume.
REQ-024 Redirect (control_en_i=1) SHALL have priority over all other events in every state: pc <= {control_pc_i[INST_AW-1:2], 2'b00}, next state S_REQ except in S_WAIT with no response that cycle.
REQ-025 Redirect in S_WAIT without same-cycle response: set drop=1, stay S_WAIT; later response discarded, drop cleared, -> S_REQ with redirected pc.
REQ-026 Redirect in S_WAIT with same-cycle response: response discarded, drop unchanged at 0, -> S_REQ.
REQ-027 Redirect in S_HOLD: instruction discarded, inst_valid_o low next cycle, no count increment even if inst_ready_i high.
REQ-028 Redirect in S_REQ: no request presented that cycle; address updates next cycle.
REQ-029 Repeat redirect while drop=1: pc updated, drop stays 1, still only one response discarded.
REQ-030 misalign_o SHALL pulse the cycle after a redirect whose control_pc_i[1:0] != 0.
REQ-031 imem_rsp_valid_i outside S_WAIT SHALL be ignored.

Reset
REQ-032 While rst=0: state S_REQ, pc=PC_START, drop=0, inst_valid_o=0, inst_o=0, inst_pc_o=0, misalign_o=0, inst_cnt_o=0; imem_req_valid_o=1 first cycle after release, addr PC_START.
REQ-033 Reset asserted mid-transaction SHALL abort it; any response arriving after release while in S_REQ is ignored.

Verification
REQ-034 Release reset, ready=1, response 2 cycles later data 32'h0000_0013, inst_ready_i=1 -> inst_valid_o=1, inst_pc_o=32'h8000_0000, next addr 32'h8000_0004, inst_cnt_o=1.
REQ-035 Redirect to 32'h8000_0100 during S_WAIT, response 32'hDEAD_BEEF next cycle -> discarded, next request addr 32'h8000_0100, inst_valid_o stays 0.
REQ-036 Hold inst_ready_i=0 for 5 cycles in S_HOLD -> inst_o/inst_pc_o stable, no new request, count unchanged.
REQ-037 Redirect to 32'h8000_0202 -> misalign_o pulses one cycle, next addr 32'h8000_0200.
REQ-038 Redirect coincident with inst_ready_i in S_HOLD -> inst_cnt_o unchanged, next addr = target.
REQ-039 rst=0 asynchronously while in S_WAIT -> all outputs at reset values immediately; post-release addr 32'h8000_0000.
